// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: load/data and display-drive signals of the 4-digit 7-segment scanner.
interface seg7_scan_mux_if;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic        frame_tick;
    modport master (output load, digits_in, dp_in, input seg_out, dp_out, dig_sel, frame_tick);
    modport slave (input load, digits_in, dp_in, output seg_out, dp_out, dig_sel, frame_tick);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 4-digit BCD 7-segment driver with frame-synchronous updates.
// Define SEG7_LZ_BLANK_EN to blank leading zeros in digits 3..1.
module seg7_scan_mux #(
    parameter int SCAN_DIV = 1000
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_mux_if.slave bus
);
    logic [15:0] pcnt;
    logic [1:0]  idx;
    logic [15:0] act_d, pend_d;
    logic [3:0]  act_p, pend_p;
    logic        pend_flag;
    logic        pcnt_wrap, frame_wrap;
    logic [3:0]  cur;
    logic [6:0]  font, seg_nxt;
    assign pcnt_wrap  = pcnt == 16'(SCAN_DIV - 1);
    assign frame_wrap = pcnt_wrap && idx == 2'd3;
    assign cur        = act_d[{idx, 2'b00} +: 4];
    always_comb begin
        case (cur)
            4'd0:    font = 7'b0111111;
            4'd1:    font = 7'b0000110;
            4'd2:    font = 7'b1011011;
            4'd3:    font = 7'b1001111;
            4'd4:    font = 7'b1100110;
            4'd5:    font = 7'b1101101;
            4'd6:    font = 7'b1111101;
            4'd7:    font = 7'b0000111;
            4'd8:    font = 7'b1111111;
            4'd9:    font = 7'b1101111;
            default: font = 7'b0000000;
        endcase
    end
`ifdef SEG7_LZ_BLANK_EN
    logic blank;
    // a digit is blank only if it and every digit to its left are zero
    assign blank = (idx == 2'd3 && act_d[15:12] == 4'd0) ||
                   (idx == 2'd2 && act_d[15:8] == 8'd0) ||
                   (idx == 2'd1 && act_d[15:4] == 12'd0);
    assign seg_nxt = blank ? 7'd0 : font;
`else
    assign seg_nxt = font;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            idx       <= '0;
            act_d     <= '0;
            act_p     <= '0;
            pend_d    <= '0;
            pend_p    <= '0;
            pend_flag <= 1'b0;
        end else begin
            pcnt <= pcnt_wrap ? 16'd0 : pcnt + 16'd1;
            if (pcnt_wrap)
                idx <= idx + 2'd1;
            if (bus.load) begin
                pend_d <= bus.digits_in;
                pend_p <= bus.dp_in;
            end
            // a load landing on the transfer edge goes straight to the active set
            if (frame_wrap) begin
                pend_flag <= 1'b0;
                if (bus.load) begin
                    act_d <= bus.digits_in;
                    act_p <= bus.dp_in;
                end else if (pend_flag) begin
                    act_d <= pend_d;
                    act_p <= pend_p;
                end
            end else if (bus.load)
                pend_flag <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_out    <= '0;
            bus.dp_out     <= 1'b0;
            bus.dig_sel    <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.seg_out    <= pcnt == 16'd0 ? 7'd0 : seg_nxt;
            bus.dp_out     <= pcnt != 16'd0 && act_p[idx];
            bus.dig_sel    <= pcnt == 16'd0 ? 4'd0 : 4'd1 << idx;
            bus.frame_tick <= frame_wrap;
        end
    end
endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  single-cycle strobe requesting capture of digits_in and dp_in.
REQ-005 digits_in  input  16  four BCD digits, [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-006 dp_in  input  4  decimal-point request per digit, bit n = digit n.
REQ-007 seg_out  output  7  segments GFEDCBA (bit 6..0), active-high, registered.
REQ-008 dp_out  output  1  decimal point of the digit being driven, active-high, registered.
REQ-009 dig_sel  output  4  one-hot digit enable, active-high, all-zero during the ghost blank, registered.
REQ-010 frame_tick  output  1  one-cycle pulse per completed 4-digit scan, registered.

Function
REQ-011 The prescaler pcnt SHALL count 0..SCAN_DIV-1 and wrap to 0; the slot index idx (0..3) SHALL advance on the edge where pcnt wraps; idx 3 SHALL wrap to 0.
REQ-012 All outputs SHALL be registered with one cycle of latency: the outputs after edge k reflect the pcnt, idx and active registers held before edge k.
REQ-013 Ghost blank: when pcnt==0, dig_sel, seg_out and dp_out SHALL all be 0; otherwise dig_sel SHALL equal 1<<idx.
REQ-014 Decode: values 0-9 SHALL map to the standard GFEDCBA patterns (0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111); values 10-15 SHALL give seg_out=0000000.
REQ-015 load=1 SHALL capture digits_in and dp_in into a pending register and set a pending flag; a later load before transfer SHALL overwrite the pending register (last load wins).
REQ-016 Transfer: on the edge where idx wraps 3->0, a set pending flag SHALL copy pending into the active registers and clear the flag, so a displayed frame never mixes old and new values.
REQ-017 A load on the transfer edge itself: the load value SHALL be the one transferred, and the flag SHALL end cleared.
REQ-018 frame_tick SHALL be 1 for exactly one cycle, on the output cycle following the idx 3->0 wrap edge.
REQ-019 dp_out SHALL equal the active dp bit of idx when pcnt!=0.

Reset
REQ-020 While rst_n=0: pcnt=0, idx=0, active and pending registers=0, pending flag=0, seg_out=0, dp_out=0, dig_sel=0, frame_tick=0, regardless of clk.
REQ-021 Reset asserted mid-frame SHALL discard any pending load; after release, scanning SHALL restart at idx 0, pcnt 0.

Configuration
REQ-022 Macro SEG7_LZ_BLANK_EN: when defined, digit n (n=3,2,1) SHALL be blanked (seg_out=0) if it and every higher active digit equal 0; digit 0 is never blanked; dp_out is unaffected.
REQ-023 Without SEG7_LZ_BLANK_EN, zeros SHALL display as "0" in every position and the blanking logic SHALL be absent.

Verification (SCAN_DIV=4)
REQ-024 Reset, then load digits_in=16'h1234, dp_in=4'b0000 in the first cycle -> frame 1 shows all-zero digits; from frame 2 on, dig_sel 0001 shows 4 (1100110), 0010 shows 3, 0100 shows 2, 1000 shows 1; each digit enabled for 3 of every 4 cycles.
REQ-025 Free-running scan -> frame_tick period exactly 16 cycles, width 1; dig_sel=0000 on every 4th cycle.
REQ-026 Loads 16'h1111 then 16'h2222 in the same frame -> the next frame shows only 2s; 1s never appear.
REQ-027 digits_in=16'h00A5, dp_in=4'b0010 -> digit 1 shows 0000000 (value A) with dp_out=1 while dig_sel=0010; with SEG7_LZ_BLANK_EN, digits 3 and 2 also blank.
REQ-028 digits_in=16'h0000 with SEG7_LZ_BLANK_EN -> digit 0 shows 0111111 and digits 1-3 blank; rst_n pulsed low mid-frame -> outputs go to 0 immediately and scanning restarts at idx 0.
